ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Fetch-side counterpart of the next-PC logic: owns the PC register and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a 2-entry FIFO and presents {instr, pc, pc+4} to decode over valid/ready.
- Accepts the resolved target (npc) from decode/NPC as a redirect, which flushes stale fetches.
- Sits between IM and the decode/NPC stage.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- FIFO_DEPTH, 2, output buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- redirect  in  1  one-cycle pulse: fetch from redirect_pc
- redirect_pc  in  32  target address from NPC
- im_req  out  1  IM read request
- im_addr  out  32  IM word address
- im_gnt  in  1  IM accepts request this cycle
- im_rvalid  in  1  read data valid (≥1 cycle after gnt)
- im_rdata  in  32  instruction word
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode accepts head
- instr  out  32  head instruction
- instr_pc  out  32  head PC
- instr_pc4  out  32  head PC + 4
- align_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset (async assert, sync release): fetch_pc = RESET_PC; FIFO empty; state = REQ; im_req = 0; im_addr = RESET_PC; instr_valid = 0; instr/instr_pc/instr_pc4 = 0; align_err = 0; redir_pend = 0. im_req first rises in the first cycle after release.
- Alignment: redirect_pc[1:0] forced to 00. If they were nonzero, align_err pulses in the redirect cycle.
- At most one IM transaction is outstanding. A request is issued only when FIFO count < 2. im_req and im_addr stay stable from assertion until gnt.
- States:
  - REQ: im_req = 1, im_addr = fetch_pc.
    - gnt with no redirect this cycle and redir_pend = 0 -> WAIT.
    - gnt with redirect or redir_pend -> DROP; fetch_pc <= target; redir_pend <= 0.
    - redirect without gnt -> stay in REQ; latch target into redir_pc; redir_pend <= 1; the address does not change.
  - WAIT:
    - rvalid, no redirect -> push {fetch_pc, im_rdata}; fetch_pc <= fetch_pc + 4 (32-bit wrap). Next state is REQ if post-push count < 2, else HOLD.
    - rvalid and redirect same cycle -> data discarded; fetch_pc <= target; -> REQ.
    - redirect without rvalid -> fetch_pc <= target; -> DROP.
  - DROP: im_req = 0. rvalid is discarded, then -> REQ. A redirect in DROP updates fetch_pc only.
  - HOLD: im_req = 0. -> REQ once count < 2 (a pop this cycle counts). A redirect in HOLD -> REQ with fetch_pc <= target.
- Redirect flushes every FIFO entry. A head handshake (instr_valid & instr_ready) in the same cycle still completes; the flushed entries are not presented afterwards.
- FIFO: simultaneous push and pop when full is illegal and cannot occur (HOLD). Push and pop in the same cycle at count 1 leaves count at 1. Output is first-word-fall-through: the head is visible the cycle after its push.
- instr_pc4 = instr_pc + 4, registered with the entry.
- Latency: request issued at T with gnt at T and rvalid at T+1 -> instr_valid at T+2. Back-to-back request at T+2, giving 1 instruction per 2 cycles for 1-cycle IM.
- Reset mid-transaction: all state is cleared immediately. Any later im_rvalid arriving while in REQ before a gnt is ignored.

Test Plan:
- Release reset, IM gnt immediate, rvalid +1 cycle, ready = 1 -> im_addr sequence 0x3000, 0x3004, 0x3008; decode sees pc 0x3000 with instr_pc4 0x3004 first; align_err stays 0.
- Hold instr_ready = 0 for 10 cycles -> FIFO fills to 2 (0x3000, 0x3004); im_req stays 0 in HOLD. Raise ready -> 0x3000 then 0x3004 delivered in order, then fetch resumes at 0x3008.
- Redirect to 0x0000_3100 while in WAIT for 0x3008 -> 0x3008 response dropped, FIFO flushed; next im_addr = 0x3100; decode next sees pc 0x3100.
- Redirect to 0x3200 while im_req pending and gnt held low 3 cycles -> im_addr stays 0x3008 until gnt; its data is dropped; next request is 0x3200.
- Redirect to 0x0000_3102 -> align_err pulses 1 cycle; fetch from 0x3100.
- Assert reset low during WAIT -> outputs return to reset values immediately; after release first im_addr = 0x3000.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch-side bundle: redirect input, IM req/gnt/rvalid bus and the decode valid/ready stream.
// slave is the fetch unit's view, master is the environment (IM, decode, NPC).
interface ifu_fetch_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        align_err;

    modport slave (
        input  redirect, redirect_pc, im_gnt, im_rvalid, im_rdata, instr_ready,
        output im_req, im_addr, instr_valid, instr, instr_pc, instr_pc4, align_err
    );

    modport master (
        output redirect, redirect_pc, im_gnt, im_rvalid, im_rdata, instr_ready,
        input  im_req, im_addr, instr_valid, instr, instr_pc, instr_pc4, align_err
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps one IM read outstanding and buffers
// returned words in a 2-entry first-word-fall-through FIFO toward decode.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    ifu_fetch_if.slave bus
);
    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_fetch_pc, w_fetch_pc_next;
    logic [31:0] r_redir_pc, w_redir_pc_next;
    logic        r_redir_pend, w_redir_pend_next;
    logic        r_started;
    logic [95:0] r_mem [2];
    logic        r_wr_ptr, r_rd_ptr;
    logic [1:0]  r_count, w_count_pop;
    logic        w_req, w_gnt, w_pop, w_push;
    logic [31:0] w_redir_al, w_target;

    assign w_redir_al  = {bus.redirect_pc[31:2], 2'b00};
    assign w_target    = bus.redirect ? w_redir_al : r_redir_pc;
    // r_started keeps im_req low through the first cycle after reset release
    assign w_req       = (r_state == S_REQ) && r_started && (r_count < DEPTH);
    assign w_gnt       = w_req && bus.im_gnt;
    assign w_pop       = (r_count != 2'd0) && bus.instr_ready;
    assign w_count_pop = r_count - {1'b0, w_pop};

    always_comb begin
        w_state_next      = r_state;
        w_fetch_pc_next   = r_fetch_pc;
        w_redir_pc_next   = r_redir_pc;
        w_redir_pend_next = r_redir_pend;
        w_push            = 1'b0;
        case (r_state)
            S_REQ: begin
                if (w_gnt) begin
                    if (bus.redirect || r_redir_pend) begin
                        w_state_next      = S_DROP;
                        w_fetch_pc_next   = w_target;
                        w_redir_pend_next = 1'b0;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end else if (bus.redirect) begin
                    // address must stay stable until gnt; remember the target
                    w_redir_pc_next   = w_redir_al;
                    w_redir_pend_next = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.redirect) begin
                    w_fetch_pc_next   = w_redir_al;
                    w_redir_pend_next = 1'b0;
                    w_state_next      = bus.im_rvalid ? S_REQ : S_DROP;
                end else if (bus.im_rvalid) begin
                    w_push          = 1'b1;
                    w_fetch_pc_next = r_fetch_pc + 32'd4;
                    w_state_next    = ((w_count_pop + 2'd1) < DEPTH) ? S_REQ : S_HOLD;
                end
            end
            S_DROP: begin
                if (bus.redirect) begin
                    w_fetch_pc_next = w_redir_al;
                end
                if (bus.im_rvalid) begin
                    w_state_next = S_REQ;
                end
            end
            S_HOLD: begin
                if (bus.redirect) begin
                    w_fetch_pc_next = w_redir_al;
                    w_state_next    = S_REQ;
                end else if (w_count_pop < DEPTH) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_REQ;
            r_fetch_pc   <= RESET_PC;
            r_redir_pc   <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_started    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fetch_pc   <= w_fetch_pc_next;
            r_redir_pc   <= w_redir_pc_next;
            r_redir_pend <= w_redir_pend_next;
            r_started    <= 1'b1;
        end
    end

    // A redirect flushes all entries; a head pop in the same cycle still completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else if (bus.redirect) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            r_count <= w_count_pop + {1'b0, w_push};
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_mem[gi] <= '0;
                end else if (w_push && (r_wr_ptr == 1'(gi))) begin
                    r_mem[gi] <= {r_fetch_pc + 32'd4, r_fetch_pc, bus.im_rdata};
                end
            end
        end
    endgenerate

    assign bus.im_req      = w_req;
    assign bus.im_addr     = r_fetch_pc;
    assign bus.instr_valid = (r_count != 2'd0);
    assign bus.instr       = r_mem[r_rd_ptr][31:0];
    assign bus.instr_pc    = r_mem[r_rd_ptr][63:32];
    assign bus.instr_pc4   = r_mem[r_rd_ptr][95:64];
    assign bus.align_err   = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a small IM responder (gnt gated by gnt_en, rvalid one
// cycle after gnt) plus monitors that log granted addresses and delivered entries.
module tb_ifu_fetch;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        int          cyc;
    } del_t;

    logic        clk;
    logic        reset;
    logic        gnt_en;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data  = 32'h0;
    int          cyc       = 0;
    int          align_cnt = 0;
    int          n_chk     = 0;
    int          n_pass    = 0;
    logic [31:0] req_q[$];
    int          gcyc_q[$];
    del_t        del_q[$];
    int          rb, db, ab;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(32'h0000_3000), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign bus.im_gnt    = bus.im_req & gnt_en;
    assign bus.im_rvalid = rsp_valid;
    assign bus.im_rdata  = rsp_data;

    always @(posedge clk) begin : responder
        logic        g;
        logic [31:0] a;
        g = bus.im_gnt;
        a = bus.im_addr;
        #1;
        rsp_valid = g;
        rsp_data  = g ? imem(a) : 32'h0;
    end

    always @(posedge clk) begin : monitor
        cyc <= cyc + 1;
        if (reset && bus.im_req && bus.im_gnt) begin
            req_q.push_back(bus.im_addr);
            gcyc_q.push_back(cyc);
        end
        if (reset && bus.instr_valid && bus.instr_ready) begin
            del_q.push_back('{bus.instr, bus.instr_pc, bus.instr_pc4, cyc});
        end
        if (bus.align_err) begin
            align_cnt <= align_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic nstep(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] req_at(input int i);
        if (i < req_q.size()) return req_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic del_t del_at(input int i);
        del_t d;
        d = '{32'hxxxx_xxxx, 32'hxxxx_xxxx, 32'hxxxx_xxxx, -1000};
        if (i < del_q.size()) d = del_q[i];
        return d;
    endfunction

    function automatic int gcyc_at(input int i);
        if (i < gcyc_q.size()) return gcyc_q[i];
        return -1000;
    endfunction

    task automatic wait_cnt(input string tag, input int want_req, input int want_del, input int max);
        int n = 0;
        while ((req_q.size() < want_req || del_q.size() < want_del) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'((req_q.size() >= want_req) && (del_q.size() >= want_del)), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        nstep(2);
        reset = 1'b1;
    endtask

    initial begin
        clk             = 1'b0;
        reset           = 1'b1;
        gnt_en          = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.instr_ready = 1'b1;
        #2 reset = 1'b0;
        nstep(3);
        chk("rst_im_req", 32'(bus.im_req), 32'd0);
        chk("rst_im_addr", bus.im_addr, 32'h3000);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_pc", bus.instr_pc, 32'h0);
        chk("rst_pc4", bus.instr_pc4, 32'h0);
        chk("rst_align", 32'(bus.align_err), 32'd0);

        // streaming fetch with an always-ready decode
        rb = req_q.size(); db = del_q.size(); ab = align_cnt;
        reset = 1'b1;
        #1 chk("rel_req_low", 32'(bus.im_req), 32'd0);
        nstep(1);
        chk("first_req", 32'(bus.im_req), 32'd1);
        chk("first_addr", bus.im_addr, 32'h3000);
        wait_cnt("t1_wait", rb + 3, db + 1, 30);
        chk("t1_addr0", req_at(rb), 32'h3000);
        chk("t1_addr1", req_at(rb + 1), 32'h3004);
        chk("t1_addr2", req_at(rb + 2), 32'h3008);
        chk("t1_pc", del_at(db).pc, 32'h3000);
        chk("t1_pc4", del_at(db).pc4, 32'h3004);
        chk("t1_instr", del_at(db).instr, imem(32'h3000));
        chk("t1_latency", 32'(del_at(db).cyc - gcyc_at(rb)), 32'd2);
        chk("t1_align", 32'(align_cnt - ab), 32'd0);

        // decode stalls: FIFO fills, fetch holds
        bus.instr_ready = 1'b0;
        do_reset();
        rb = req_q.size(); db = del_q.size();
        nstep(10);
        chk("t2_hold_req", 32'(bus.im_req), 32'd0);
        chk("t2_valid", 32'(bus.instr_valid), 32'd1);
        chk("t2_head_pc", bus.instr_pc, 32'h3000);
        chk("t2_head_pc4", bus.instr_pc4, 32'h3004);
        chk("t2_nreq", 32'(req_q.size() - rb), 32'd2);
        bus.instr_ready = 1'b1;
        nstep(1);
        bus.instr_ready = 1'b0;
        chk("t2_resume_req", 32'(bus.im_req), 32'd1);
        chk("t2_resume_addr", bus.im_addr, 32'h3008);
        chk("t2_head2_pc", bus.instr_pc, 32'h3004);
        nstep(1);
        chk("t3_wait_valid", 32'(bus.instr_valid), 32'd1);
        // redirect while the 0x3008 response is returning
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_3100;
        nstep(1);
        bus.redirect = 1'b0;
        chk("t3_flushed", 32'(bus.instr_valid), 32'd0);
        chk("t3_req", 32'(bus.im_req), 32'd1);
        chk("t3_addr", bus.im_addr, 32'h3100);
        bus.instr_ready = 1'b1;
        wait_cnt("t3_wait", 0, db + 2, 20);
        chk("t3_del0", del_at(db).pc, 32'h3000);
        chk("t3_del1", del_at(db + 1).pc, 32'h3100);
        chk("t3_del1_pc4", del_at(db + 1).pc4, 32'h3104);
        chk("t3_del1_instr", del_at(db + 1).instr, imem(32'h3100));

        // redirect while a request waits for gnt
        bus.instr_ready = 1'b1;
        gnt_en = 1'b1;
        do_reset();
        rb = req_q.size(); db = del_q.size();
        nstep(4);
        gnt_en = 1'b0;
        nstep(1);
        chk("t4_req", 32'(bus.im_req), 32'd1);
        chk("t4_addr", bus.im_addr, 32'h3008);
        chk("t4_head", bus.instr_pc, 32'h3004);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_3200;
        nstep(1);
        bus.redirect = 1'b0;
        chk("t4_stable1", bus.im_addr, 32'h3008);
        chk("t4_stable_req", 32'(bus.im_req), 32'd1);
        chk("t4_flushed", 32'(bus.instr_valid), 32'd0);
        nstep(1);
        chk("t4_stable2", bus.im_addr, 32'h3008);
        nstep(1);
        gnt_en = 1'b1;
        chk("t4_stable3", bus.im_addr, 32'h3008);
        nstep(1);
        chk("t4_drop_req", 32'(bus.im_req), 32'd0);
        nstep(1);
        chk("t4_new_req", 32'(bus.im_req), 32'd1);
        chk("t4_new_addr", bus.im_addr, 32'h3200);
        wait_cnt("t4_wait", rb + 4, db + 3, 20);
        chk("t4_gnt_old", req_at(rb + 2), 32'h3008);
        chk("t4_gnt_new", req_at(rb + 3), 32'h3200);
        chk("t4_del_same_cycle", del_at(db + 1).pc, 32'h3004);
        chk("t4_del_new", del_at(db + 2).pc, 32'h3200);

        // misaligned redirect target
        db = del_q.size(); ab = align_cnt;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_3102;
        #1 chk("t5_align_hi", 32'(bus.align_err), 32'd1);
        nstep(1);
        bus.redirect = 1'b0;
        #1 chk("t5_align_lo", 32'(bus.align_err), 32'd0);
        chk("t5_align_pulses", 32'(align_cnt - ab), 32'd1);
        bus.instr_ready = 1'b1;
        wait_cnt("t5_wait", 0, db + 1, 20);
        chk("t5_pc", del_at(db).pc, 32'h3100);
        chk("t5_pc4", del_at(db).pc4, 32'h3104);
        chk("t5_instr", del_at(db).instr, imem(32'h3100));

        // reset asserted while waiting for 0x3004
        bus.instr_ready = 1'b0;
        do_reset();
        nstep(4);
        chk("t6_pre_valid", 32'(bus.instr_valid), 32'd1);
        chk("t6_pre_addr", bus.im_addr, 32'h3004);
        reset = 1'b0;
        #1;
        chk("t6_req", 32'(bus.im_req), 32'd0);
        chk("t6_addr", bus.im_addr, 32'h3000);
        chk("t6_valid", 32'(bus.instr_valid), 32'd0);
        chk("t6_instr", bus.instr, 32'h0);
        chk("t6_pc", bus.instr_pc, 32'h0);
        chk("t6_pc4", bus.instr_pc4, 32'h0);
        nstep(1);
        rb = req_q.size(); db = del_q.size();
        bus.instr_ready = 1'b1;
        reset = 1'b1;
        nstep(1);
        chk("t6_first_req", 32'(bus.im_req), 32'd1);
        chk("t6_first_addr", bus.im_addr, 32'h3000);
        wait_cnt("t6_wait", rb + 1, db + 1, 20);
        chk("t6_gnt_addr", req_at(rb), 32'h3000);
        chk("t6_del_pc", del_at(db).pc, 32'h3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
